// File: rtl/interrupt_controller_pkg.sv
// Shared types and limits for the interrupt controller.
package interrupt_controller_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2,
      HOLD    = 2'd3
   } state_t;

   localparam int N_INT_MAX       = 8;
   localparam int SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/interrupt_controller_if.sv
// Core-side mask/handshake bus; master = processor core, slave = controller.
interface interrupt_controller_if #(
   parameter int N_INT = 4
);
   logic             i_mask_wr;
   logic [N_INT-1:0] i_mask_data;
   logic             i_ack;
   logic             i_done;
   logic             o_int_req;
   logic [N_INT-1:0] o_snapshot;
   logic [N_INT-1:0] o_mask;
   logic [N_INT-1:0] o_overflow;

   modport master (
      output i_mask_wr, i_mask_data, i_ack, i_done,
      input  o_int_req, o_snapshot, o_mask, o_overflow
   );

   modport slave (
      input  i_mask_wr, i_mask_data, i_ack, i_done,
      output o_int_req, o_snapshot, o_mask, o_overflow
   );
endinterface

// File: rtl/interrupt_controller_sync_detect.sv
// Per-source synchronizer chain followed by rising-edge or level-high event detect.
module interrupt_sync_detect
   import interrupt_controller_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_MIN,
   parameter bit EDGE        = 1'b1
) (
   input  logic s_clk,
   input  logic s_rst,
   input  logic i_line,
   output logic o_event
);
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge s_clk or negedge s_rst) begin
      if (!s_rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], i_line};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign o_event = EDGE ? (sync_q[SYNC_STAGES-1] & ~prev_q) : sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/interrupt_controller.sv
// Interrupt receiver: sync/detect, pending latch, mask, request/ack/done FSM.
// Optional lost-event flags built when INTERRUPT_CONTROLLER_OVERFLOW_EN is defined.
module interrupt_controller
   import interrupt_controller_pkg::*;
#(
   parameter int         N_INT       = 4,
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] EDGE_MODE   = 8'hFF,
   parameter logic [7:0] INIT_MASK   = 8'hFF
) (
   input  logic                    s_clk,
   input  logic                    s_rst,
   input  logic [N_INT-1:0]        i_interrupt,
   interrupt_controller_if.slave   bus
);
   state_t           state;
   logic [N_INT-1:0] evt;
   logic [N_INT-1:0] pend;
   logic [N_INT-1:0] req_vec;
   logic             ack_take;
   logic             mask_kill;

   for (genvar g = 0; g < N_INT; g++) begin : g_src
      interrupt_sync_detect #(
         .SYNC_STAGES (SYNC_STAGES),
         .EDGE        (EDGE_MODE[g])
      ) u_sync_detect (
         .s_clk   (s_clk),
         .s_rst   (s_rst),
         .i_line  (i_interrupt[g]),
         .o_event (evt[g])
      );
   end

   assign req_vec   = pend & bus.o_mask;
   assign ack_take  = (state == REQ) && bus.i_ack;
   // A mask write that leaves nothing enabled pending cancels a request.
   assign mask_kill = bus.i_mask_wr && !(|(pend & bus.i_mask_data));

   // Events on the clearing edge win, so level sources re-pend immediately.
   always_ff @(posedge s_clk or negedge s_rst) begin
      if (!s_rst) pend <= '0;
      else        pend <= (pend & ~(ack_take ? req_vec : '0)) | evt;
   end

   always_ff @(posedge s_clk or negedge s_rst) begin
      if (!s_rst)              bus.o_mask <= INIT_MASK[N_INT-1:0];
      else if (bus.i_mask_wr)  bus.o_mask <= bus.i_mask_data;
   end

   always_ff @(posedge s_clk or negedge s_rst) begin
      if (!s_rst) begin
         state          <= IDLE;
         bus.o_int_req  <= 1'b0;
         bus.o_snapshot <= '0;
      end else begin
         case (state)
            IDLE: if ((|req_vec) && !mask_kill) begin
               state         <= REQ;
               bus.o_int_req <= 1'b1;
            end
            REQ: if (bus.i_ack) begin
               state          <= SERVICE;
               bus.o_int_req  <= 1'b0;
               bus.o_snapshot <= req_vec;
            end else if (mask_kill) begin
               state         <= IDLE;
               bus.o_int_req <= 1'b0;
            end
            SERVICE: if (bus.i_done) state <= HOLD;
            HOLD:    state <= IDLE;
            default: begin
               state         <= IDLE;
               bus.o_int_req <= 1'b0;
            end
         endcase
      end
   end

`ifdef INTERRUPT_CONTROLLER_OVERFLOW_EN
   always_ff @(posedge s_clk or negedge s_rst) begin
      if (!s_rst) bus.o_overflow <= '0;
      else        bus.o_overflow <= (ack_take ? '0 : bus.o_overflow) |
                                    (evt & pend & EDGE_MODE[N_INT-1:0]);
   end
`else
   assign bus.o_overflow = '0;
`endif
endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller; source 3 is level-triggered.
module tb_interrupt_controller;
   import interrupt_controller_pkg::*;

   logic       s_clk = 1'b0;
   logic       s_rst = 1'b0;
   logic [3:0] i_interrupt = '0;
   int         checks = 0;
   int         errors = 0;

   interrupt_controller_if #(.N_INT(4)) bus ();

   interrupt_controller #(
      .N_INT       (4),
      .SYNC_STAGES (2),
      .EDGE_MODE   (8'hF7),
      .INIT_MASK   (8'hFF)
   ) dut (
      .s_clk       (s_clk),
      .s_rst       (s_rst),
      .i_interrupt (i_interrupt),
      .bus         (bus)
   );

   always #5 s_clk = ~s_clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge s_clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic pulse(input logic [3:0] v);
      i_interrupt = v;
      tick();
      i_interrupt = '0;
   endtask

   task automatic mask_write(input logic [3:0] m);
      bus.i_mask_wr   = 1'b1;
      bus.i_mask_data = m;
      tick();
      bus.i_mask_wr   = 1'b0;
   endtask

   task automatic do_ack(input string tag, input logic [3:0] snap);
      bus.i_ack = 1'b1;
      tick();
      bus.i_ack = 1'b0;
      chk({tag, "_snap"}, 32'(bus.o_snapshot), 32'(snap));
      chk({tag, "_req0"}, 32'(bus.o_int_req), 32'd0);
   endtask

   task automatic do_done(input string tag);
      bus.i_done = 1'b1;
      tick();
      bus.i_done = 1'b0;
      chk({tag, "_hold"}, 32'(dut.state), 32'(HOLD));
      tick();
      chk({tag, "_idle"}, 32'(dut.state), 32'(IDLE));
   endtask

   initial begin
      logic [3:0] ovf_exp;
      bus.i_mask_wr   = 1'b0;
      bus.i_mask_data = '0;
      bus.i_ack       = 1'b0;
      bus.i_done      = 1'b0;
`ifdef INTERRUPT_CONTROLLER_OVERFLOW_EN
      ovf_exp = 4'b0001;
`else
      ovf_exp = 4'b0000;
`endif
      #23;
      chk("rst_req",  32'(bus.o_int_req),  32'd0);
      chk("rst_mask", 32'(bus.o_mask),     32'hF);
      chk("rst_snap", 32'(bus.o_snapshot), 32'd0);
      chk("rst_ovf",  32'(bus.o_overflow), 32'd0);
      chk("rst_st",   32'(dut.state),      32'(IDLE));
      s_rst = 1'b1;
      ticks(10);

      // single edge source: pend at +3, request at +4
      pulse(4'b0001);
      tick();
      chk("t1_pend2", 32'(dut.pend), 32'd0);
      tick();
      chk("t1_pend3", 32'(dut.pend), 32'h1);
      chk("t1_req3",  32'(bus.o_int_req), 32'd0);
      tick();
      chk("t1_req4",  32'(bus.o_int_req), 32'd1);
      do_ack("t1", 4'b0001);
      chk("t1_pendclr", 32'(dut.pend), 32'd0);
      do_done("t1");
      ticks(4);
      chk("t1_norereq", 32'(bus.o_int_req), 32'd0);

      // two sources on the same cycle
      pulse(4'b0110);
      ticks(3);
      chk("t2_req", 32'(bus.o_int_req), 32'd1);
      do_ack("t2", 4'b0110);
      chk("t2_pend", 32'(dut.pend), 32'd0);
      do_done("t2");

      // masked event is remembered, request 2 cycles after unmask strobe
      mask_write(4'b1110);
      chk("t3_mask", 32'(bus.o_mask), 32'hE);
      pulse(4'b0001);
      ticks(6);
      chk("t3_noreq", 32'(bus.o_int_req), 32'd0);
      chk("t3_pend",  32'(dut.pend), 32'h1);
      mask_write(4'b1111);
      chk("t3_req1", 32'(bus.o_int_req), 32'd0);
      tick();
      chk("t3_req2", 32'(bus.o_int_req), 32'd1);
      do_ack("t3", 4'b0001);
      do_done("t3");

      // level source 3 held across ack and done
      i_interrupt = 4'b1000;
      ticks(4);
      chk("t4_req", 32'(bus.o_int_req), 32'd1);
      do_ack("t4", 4'b1000);
      chk("t4_repend", 32'(dut.pend), 32'h8);
      ticks(2);
      do_done("t4");
      chk("t4_req_idle", 32'(bus.o_int_req), 32'd0);
      tick();
      chk("t4_rereq", 32'(bus.o_int_req), 32'd1);
      i_interrupt = '0;
      ticks(4);
      do_ack("t4b", 4'b1000);
      do_done("t4b");
      ticks(3);
      chk("t4_quiet", 32'(bus.o_int_req), 32'd0);

      // event during SERVICE waits until after HOLD
      pulse(4'b0001);
      ticks(3);
      do_ack("t5", 4'b0001);
      pulse(4'b0001);
      ticks(4);
      chk("t5_svc_req", 32'(bus.o_int_req), 32'd0);
      chk("t5_svc_pend", 32'(dut.pend), 32'h1);
      chk("t5_snap_hold", 32'(bus.o_snapshot), 32'h1);
      do_done("t5");
      chk("t5_req_idle", 32'(bus.o_int_req), 32'd0);
      tick();
      chk("t5_rereq", 32'(bus.o_int_req), 32'd1);
      do_ack("t5b", 4'b0001);
      do_done("t5b");

      // mask write withdraws a request; ack with done together takes ack
      pulse(4'b0010);
      ticks(3);
      chk("t6_req", 32'(bus.o_int_req), 32'd1);
      mask_write(4'b0000);
      chk("t6_wd_req", 32'(bus.o_int_req), 32'd0);
      chk("t6_wd_st",  32'(dut.state), 32'(IDLE));
      chk("t6_pend",   32'(dut.pend), 32'h2);
      mask_write(4'b1111);
      chk("t6_req_a", 32'(bus.o_int_req), 32'd0);
      tick();
      chk("t6_req_b", 32'(bus.o_int_req), 32'd1);
      bus.i_done = 1'b1;
      do_ack("t6", 4'b0010);
      bus.i_done = 1'b0;
      chk("t6_st_svc", 32'(dut.state), 32'(SERVICE));
      do_done("t6");

      // stray ack/done in IDLE ignored
      bus.i_ack = 1'b1;
      tick();
      bus.i_ack = 1'b0;
      chk("t7_ack_st",   32'(dut.state), 32'(IDLE));
      chk("t7_ack_snap", 32'(bus.o_snapshot), 32'h2);
      bus.i_done = 1'b1;
      tick();
      bus.i_done = 1'b0;
      chk("t7_done_st", 32'(dut.state), 32'(IDLE));

      // two pulses on source 0 before ack
      pulse(4'b0001);
      ticks(3);
      pulse(4'b0001);
      ticks(3);
      chk("t8_ovf", 32'(bus.o_overflow), 32'(ovf_exp));
      do_ack("t8", 4'b0001);
      chk("t8_ovf_clr", 32'(bus.o_overflow), 32'd0);
      do_done("t8");

      // asynchronous reset while requesting
      mask_write(4'b0101);
      pulse(4'b0100);
      ticks(3);
      chk("t9_req", 32'(bus.o_int_req), 32'd1);
      #2;
      s_rst = 1'b0;
      #1;
      chk("t9_rst_req",  32'(bus.o_int_req),  32'd0);
      chk("t9_rst_mask", 32'(bus.o_mask),     32'hF);
      chk("t9_rst_snap", 32'(bus.o_snapshot), 32'd0);
      chk("t9_rst_pend", 32'(dut.pend),       32'd0);
      #3;
      s_rst = 1'b1;
      ticks(5);
      chk("t9_post_req", 32'(bus.o_int_req), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
